// File: rtl/hdc_msg_packer_pkg.sv
// Shared HDC definitions: message geometry, packer state encoding and the
// character case-fold helper. Used by the packer, main and the encoders.
package hdc_pkg;

  localparam int MESSAGE_LENGTH = 200;
  localparam int CHAR_LENGTH    = 8;
  localparam int LENGTH_W       = 8;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } packer_state_t;

  // Upper-case ASCII letters map onto their lower-case form; everything else
  // passes through untouched.
  function automatic logic [CHAR_LENGTH-1:0] case_fold(input logic [CHAR_LENGTH-1:0] c);
    if (c >= 8'h41 && c <= 8'h5A) begin
      return c | 8'h20;
    end
    return c;
  endfunction

endpackage

// File: rtl/hdc_msg_packer_if.sv
// Byte-stream input and packed-message output bundle of the HDC message packer.
// master: the side that sources characters and consumes messages.
// slave:  the packer itself.
interface hdc_msg_packer_if #(
  parameter int MESSAGE_LENGTH = hdc_pkg::MESSAGE_LENGTH,
  parameter int CHAR_LENGTH    = hdc_pkg::CHAR_LENGTH,
  parameter int LENGTH_W       = hdc_pkg::LENGTH_W
);

  logic [CHAR_LENGTH-1:0]                in_char;
  logic                                  in_valid;
  logic                                  in_last;
  logic                                  in_ready;
  logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg;
  logic [LENGTH_W-1:0]                   length;
  logic                                  msg_valid;
  logic                                  msg_ready;
  logic                                  overflow;

  modport master (
    output in_char, in_valid, in_last, msg_ready,
    input  in_ready, msg, length, msg_valid, overflow
  );

  modport slave (
    input  in_char, in_valid, in_last, msg_ready,
    output in_ready, msg, length, msg_valid, overflow
  );

endinterface

// File: rtl/hdc_msg_packer.sv
// HDC message packer: collects a byte-serial character stream into the flat
// MSB-first message vector plus character count consumed by main, and holds
// the result until the consumer acknowledges it. Characters beyond
// MESSAGE_LENGTH are dropped and flagged through a sticky overflow bit.
// Optional build macro: HDC_CASE_FOLD_EN folds 'A'..'Z' to 'a'..'z' on store.
module hdc_msg_packer #(
  parameter int MESSAGE_LENGTH = hdc_pkg::MESSAGE_LENGTH,
  parameter int CHAR_LENGTH    = hdc_pkg::CHAR_LENGTH
) (
  input logic               clk,
  input logic               reset,
  hdc_msg_packer_if.slave   bus
);

  import hdc_pkg::*;

  localparam logic [LENGTH_W-1:0] LAST_SLOT = LENGTH_W'(MESSAGE_LENGTH - 1);

  packer_state_t state;
  packer_state_t state_next;

  // Slot 0 is the leftmost (most significant) character of the flat vector.
  logic [0:MESSAGE_LENGTH-1][CHAR_LENGTH-1:0] slots;
  logic [LENGTH_W-1:0]                        count;
  logic                                       ovf;
  logic                                       ready;
  logic                                       valid;
  logic                                       accept;
  logic [CHAR_LENGTH-1:0]                     store_char;

  assign accept = bus.in_valid && ready;

`ifdef HDC_CASE_FOLD_EN
  assign store_char = case_fold(bus.in_char);
`else
  assign store_char = bus.in_char;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: fill slots, spill into discard once full, hold on last.
  always_comb begin
    state_next = state;
    unique case (state)
      FILL: begin
        if (accept) begin
          if (bus.in_last) begin
            state_next = HOLD;
          end else if (count == LAST_SLOT) begin
            state_next = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (accept && bus.in_last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.msg_ready) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Handshake outputs depend on state alone, never on in_valid.
  always_comb begin
    ready = 1'b1;
    valid = 1'b0;
    if (state == HOLD) begin
      ready = 1'b0;
      valid = 1'b1;
    end
  end

  // Message buffer, count and sticky overflow; cleared on message hand-off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slots <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            slots[count] <= store_char;
            count        <= count + 1'b1;
          end
        end
        DISCARD: begin
          if (accept) begin
            ovf <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.msg_ready) begin
            slots <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.msg_valid = valid;
  assign bus.msg       = slots;
  assign bus.length    = count;
  assign bus.overflow  = ovf;

endmodule

// File: tb/tb_hdc_msg_packer.sv
// Self-checking bench for hdc_msg_packer. A queue-based reference model turns
// each sent character list into the expected flat message, length and
// overflow flag. Honours HDC_CASE_FOLD_EN when the build defines it.
module tb_hdc_msg_packer;

  localparam int ML = hdc_pkg::MESSAGE_LENGTH;
  localparam int CL = hdc_pkg::CHAR_LENGTH;
  localparam int MW = ML * CL;

  typedef logic [7:0] chr_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  hdc_msg_packer_if bus_if ();

  hdc_msg_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Reference model
  function automatic chr_t ref_fold(input chr_t c);
`ifdef HDC_CASE_FOLD_EN
    if (c >= "A" && c <= "Z") return c + 8'd32;
`endif
    return c;
  endfunction

  function automatic logic [MW-1:0] ref_msg(input chr_t m[$]);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < ML; i++)
      r = {r[MW-CL-1:0], (i < m.size()) ? ref_fold(m[i]) : 8'h00};
    return r;
  endfunction

  function automatic logic [7:0] ref_len(input chr_t m[$]);
    return (m.size() > ML) ? 8'(ML) : 8'(m.size());
  endfunction

  // Drivers
  task automatic beat(input chr_t c, input bit last);
    int budget;
    budget = 1000;
    bus_if.in_valid = 1'b1;
    bus_if.in_char  = c;
    bus_if.in_last  = last;
    while (!bus_if.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      $display("FAIL beat_accept: in_ready stuck at %0b, required 1 within 1000 cycles", bus_if.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
    bus_if.in_char  = 8'($urandom);
  endtask

  task automatic send_msg(input chr_t m[$], input bit gaps);
    for (int i = 0; i < m.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      beat(m[i], i == m.size() - 1);
    end
  endtask

  task automatic handshake();
    bus_if.msg_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.msg_ready = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    n_checks++; if (bus_if.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", bus_if.in_ready); else n_pass++;
    n_checks++; if (bus_if.msg_valid !== 1'b0) $display("FAIL reset_msg_valid: got %0b want 0", bus_if.msg_valid); else n_pass++;
    n_checks++; if (bus_if.length !== 8'd0) $display("FAIL reset_length: got %0d want 0", bus_if.length); else n_pass++;
    n_checks++; if (bus_if.overflow !== 1'b0) $display("FAIL reset_overflow: got %0b want 0", bus_if.overflow); else n_pass++;
    n_checks++; if (bus_if.msg !== '0) $display("FAIL reset_msg: got top %h want 0", bus_if.msg[MW-1 -: 64]); else n_pass++;
  endtask

  task automatic test_hi();
    chr_t m[$];
    m = '{8'h68, 8'h69};
    bus_if.msg_ready = 1'b1;
    send_msg(m, 1'b0);
    n_checks++; if (bus_if.msg_valid !== 1'b1) $display("FAIL hi_valid: got %0b want 1", bus_if.msg_valid); else n_pass++;
    n_checks++; if (bus_if.length !== 8'd2) $display("FAIL hi_length: got %0d want 2", bus_if.length); else n_pass++;
    n_checks++; if (bus_if.msg[MW-1 -: 16] !== 16'h6869) $display("FAIL hi_top: got %h want 6869", bus_if.msg[MW-1 -: 16]); else n_pass++;
    n_checks++; if (bus_if.msg[MW-17:0] !== '0) $display("FAIL hi_rest: got nonzero below top 16 bits, want 0"); else n_pass++;
    n_checks++; if (bus_if.overflow !== 1'b0) $display("FAIL hi_overflow: got %0b want 0", bus_if.overflow); else n_pass++;
    @(negedge clk);
    bus_if.msg_ready = 1'b0;
    n_checks++; if (bus_if.msg_valid !== 1'b0) $display("FAIL hi_release_valid: got %0b want 0", bus_if.msg_valid); else n_pass++;
    n_checks++; if (bus_if.in_ready !== 1'b1) $display("FAIL hi_release_ready: got %0b want 1", bus_if.in_ready); else n_pass++;
    n_checks++; if (bus_if.length !== 8'd0) $display("FAIL hi_release_length: got %0d want 0", bus_if.length); else n_pass++;
  endtask

  task automatic test_full();
    chr_t m[$];
    logic [MW-1:0] exp;
    m = {};
    for (int i = 0; i < ML; i++) m.push_back(8'h61);
    exp = ref_msg(m);
    send_msg(m, 1'b0);
    n_checks++; if (bus_if.msg_valid !== 1'b1) $display("FAIL full_valid: got %0b want 1", bus_if.msg_valid); else n_pass++;
    n_checks++; if (bus_if.length !== 8'd200) $display("FAIL full_length: got %0d want 200", bus_if.length); else n_pass++;
    n_checks++; if (bus_if.msg !== exp) $display("FAIL full_msg: got low %h want low %h", bus_if.msg[63:0], exp[63:0]); else n_pass++;
    n_checks++; if (bus_if.overflow !== 1'b0) $display("FAIL full_overflow: got %0b want 0", bus_if.overflow); else n_pass++;
    handshake();
  endtask

  task automatic test_overflow();
    chr_t m[$];
    logic [MW-1:0] exp;
    m = {};
    for (int i = 0; i < ML + 3; i++) m.push_back(chr_t'($urandom));
    exp = ref_msg(m);
    send_msg(m, 1'b0);
    n_checks++; if (bus_if.length !== 8'd200) $display("FAIL ovf_length: got %0d want 200", bus_if.length); else n_pass++;
    n_checks++; if (bus_if.overflow !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", bus_if.overflow); else n_pass++;
    n_checks++; if (bus_if.msg !== exp) $display("FAIL ovf_msg: got low %h want low %h", bus_if.msg[63:0], exp[63:0]); else n_pass++;
    handshake();
    n_checks++; if (bus_if.overflow !== 1'b0) $display("FAIL ovf_clear: got %0b want 0", bus_if.overflow); else n_pass++;
    n_checks++; if (bus_if.length !== 8'd0) $display("FAIL ovf_clear_length: got %0d want 0", bus_if.length); else n_pass++;
  endtask

  task automatic test_hold_stall();
    chr_t m[$];
    logic [MW-1:0] exp;
    chr_t c;
    m = {};
    for (int i = 0; i < 4; i++) m.push_back(chr_t'($urandom));
    exp = ref_msg(m);
    send_msg(m, 1'b1);
    c = chr_t'($urandom_range(32'h41, 32'h5A));
    bus_if.in_valid = 1'b1;
    bus_if.in_char  = c;
    bus_if.in_last  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (bus_if.in_ready !== 1'b0) $display("FAIL stall_in_ready: cycle %0d got %0b want 0", k, bus_if.in_ready); else n_pass++;
      n_checks++; if (bus_if.msg !== exp || bus_if.length !== 8'd4 || bus_if.msg_valid !== 1'b1)
        $display("FAIL stall_frozen: cycle %0d got len %0d valid %0b want len 4 valid 1", k, bus_if.length, bus_if.msg_valid);
      else n_pass++;
      @(negedge clk);
    end
    bus_if.msg_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.msg_ready = 1'b0;
    n_checks++; if (bus_if.msg_valid !== 1'b0) $display("FAIL stall_after_valid: got %0b want 0", bus_if.msg_valid); else n_pass++;
    n_checks++; if (bus_if.in_ready !== 1'b1) $display("FAIL stall_after_ready: got %0b want 1", bus_if.in_ready); else n_pass++;
    n_checks++; if (bus_if.msg !== '0) $display("FAIL stall_after_clear: got top %h want 0", bus_if.msg[MW-1 -: 64]); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    m = '{c};
    exp = ref_msg(m);
    n_checks++; if (bus_if.length !== 8'd1) $display("FAIL stall_next_length: got %0d want 1", bus_if.length); else n_pass++;
    n_checks++; if (bus_if.msg !== exp) $display("FAIL stall_next_msg: got top %h want top %h", bus_if.msg[MW-1 -: 64], exp[MW-1 -: 64]); else n_pass++;
    beat(8'h2E, 1'b1);
    handshake();
  endtask

  task automatic test_reset_mid();
    chr_t m[$];
    logic [MW-1:0] exp;
    for (int i = 0; i < 5; i++) beat(chr_t'($urandom), 1'b0);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus_if.msg !== '0) $display("FAIL rstmid_msg: got top %h want 0", bus_if.msg[MW-1 -: 64]); else n_pass++;
    n_checks++; if (bus_if.length !== 8'd0) $display("FAIL rstmid_length: got %0d want 0", bus_if.length); else n_pass++;
    n_checks++; if (bus_if.msg_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", bus_if.msg_valid); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    m = {};
    for (int i = 0; i < 3; i++) m.push_back(chr_t'($urandom));
    exp = ref_msg(m);
    send_msg(m, 1'b0);
    n_checks++; if (bus_if.length !== 8'd3) $display("FAIL rstmid_new_length: got %0d want 3", bus_if.length); else n_pass++;
    n_checks++; if (bus_if.msg !== exp) $display("FAIL rstmid_new_msg: got top %h want top %h", bus_if.msg[MW-1 -: 64], exp[MW-1 -: 64]); else n_pass++;
    handshake();
  endtask

  task automatic test_case_fold();
    chr_t m[$];
    logic [31:0] exp_top;
`ifdef HDC_CASE_FOLD_EN
    exp_top = 32'h7370616D;
`else
    exp_top = 32'h5350414D;
`endif
    m = '{8'h53, 8'h50, 8'h41, 8'h4D};
    send_msg(m, 1'b1);
    n_checks++; if (bus_if.msg[MW-1 -: 32] !== exp_top) $display("FAIL spam_top: got %h want %h", bus_if.msg[MW-1 -: 32], exp_top); else n_pass++;
    n_checks++; if (bus_if.length !== 8'd4) $display("FAIL spam_length: got %0d want 4", bus_if.length); else n_pass++;
    handshake();
  endtask

  task automatic test_random();
    chr_t m[$];
    logic [MW-1:0] exp;
    int lens[8];
    lens = '{1, 199, 200, 201, 2, 17, 150, 210};
    for (int t = 0; t < 8; t++) begin
      m = {};
      if (t >= 4) lens[t] = $urandom_range(2, 210);
      for (int i = 0; i < lens[t]; i++) m.push_back(chr_t'($urandom));
      exp = ref_msg(m);
      send_msg(m, 1'b1);
      n_checks++; if (bus_if.msg_valid !== 1'b1) $display("FAIL rand%0d_valid: got %0b want 1", t, bus_if.msg_valid); else n_pass++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_checks++; if (bus_if.length !== ref_len(m)) $display("FAIL rand%0d_length: got %0d want %0d", t, bus_if.length, ref_len(m)); else n_pass++;
      n_checks++; if (bus_if.overflow !== (m.size() > ML)) $display("FAIL rand%0d_overflow: got %0b want %0b", t, bus_if.overflow, m.size() > ML); else n_pass++;
      n_checks++; if (bus_if.msg !== exp) $display("FAIL rand%0d_msg: got top %h want top %h", t, bus_if.msg[MW-1 -: 64], exp[MW-1 -: 64]); else n_pass++;
      handshake();
      n_checks++; if (bus_if.msg_valid !== 1'b0 || bus_if.in_ready !== 1'b1)
        $display("FAIL rand%0d_release: got valid %0b ready %0b want 0 1", t, bus_if.msg_valid, bus_if.in_ready);
      else n_pass++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    reset            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_last   = 1'b0;
    bus_if.in_char   = 8'h00;
    bus_if.msg_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_hi();
    test_full();
    test_overflow();
    test_hold_stall();
    test_reset_mid();
    test_case_fold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
